sif_mc: RTL and testbench

SIF_MC -- requirements
Module: sif_mc

---
 rtl/sif_mc.sv | 146 ++++++++++++++
 tb/tb_sif_mc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sif_mc.sv
// -----------------------------------------------------------------------------
// sif_mc
// Register file shared by one host port and NUM_WA write agents.
// The host port reads and writes directly. Each write agent has a one-entry
// holding buffer. A round-robin arbiter drains one buffer into the register
// file in each cycle that has no host write.
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   xa_wr_s     : host write strobe
//   xa_rd_s     : host read strobe
//   xa_addr     : host address
//   xa_data_wr  : host write data
//   xa_data_rd  : host read data (holds its value between reads)
//   xa_rd_vld   : one-cycle pulse, read data is valid
//   xa_err      : one-cycle pulse, read and write strobes were both set
//   wa_wr_s     : per-agent write strobes
//   wa_addr     : packed per-agent addresses, agent i at [i*ADDR_W +: ADDR_W]
//   wa_data_wr  : packed per-agent data, agent i at [i*DATA_W +: DATA_W]
//   wa_rdy      : per-agent holding buffer is empty
//   wa_ovf      : per-agent pulse, a write was dropped because the buffer was full
// -----------------------------------------------------------------------------
module sif_mc #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int NUM_WA = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     xa_wr_s,
  input  logic                     xa_rd_s,
  input  logic [ADDR_W-1:0]        xa_addr,
  input  logic [DATA_W-1:0]        xa_data_wr,
  output logic [DATA_W-1:0]        xa_data_rd,
  output logic                     xa_rd_vld,
  output logic                     xa_err,
  input  logic [NUM_WA-1:0]        wa_wr_s,
  input  logic [NUM_WA*ADDR_W-1:0] wa_addr,
  input  logic [NUM_WA*DATA_W-1:0] wa_data_wr,
  output logic [NUM_WA-1:0]        wa_rdy,
  output logic [NUM_WA-1:0]        wa_ovf
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LG_W  = (NUM_WA > 1) ? $clog2(NUM_WA) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NUM_WA-1:0] r_valid;
  logic [ADDR_W-1:0] r_bufAddr [NUM_WA];
  logic [DATA_W-1:0] r_bufData [NUM_WA];
  logic [LG_W-1:0]   r_lastGrant;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdVld;
  logic              r_err;
  logic [NUM_WA-1:0] r_ovf;

  logic              w_hostWr;
  logic              w_hostRd;
  logic              w_hostErr;
  logic              w_grantVld;
  logic [LG_W-1:0]   w_grantIdx;

  // Candidate channel k steps after the last grant, with wrap-around.
  function automatic logic [LG_W-1:0] nextIdx(input logic [LG_W-1:0] last, input int k);
    return LG_W'((int'(last) + k) % NUM_WA);
  endfunction

  assign w_hostWr  = xa_wr_s & ~xa_rd_s;
  assign w_hostRd  = xa_rd_s & ~xa_wr_s;
  assign w_hostErr = xa_wr_s &  xa_rd_s;

  assign xa_data_rd = r_rdData;
  assign xa_rd_vld  = r_rdVld;
  assign xa_err     = r_err;
  assign wa_rdy     = ~r_valid;
  assign wa_ovf     = r_ovf;

  // Round-robin search that starts one past the last grant. A host write
  // blocks every grant, so the register file sees at most one write per cycle.
  // The search wraps back to the last granted channel, so that channel can be
  // granted again if it is the only one with a pending entry.
  always_comb begin
    w_grantVld = 1'b0;
    w_grantIdx = r_lastGrant;
    if (!w_hostWr) begin
      for (int k = 1; k <= NUM_WA; k++) begin
        if (!w_grantVld && r_valid[nextIdx(r_lastGrant, k)]) begin
          w_grantVld = 1'b1;
          w_grantIdx = nextIdx(r_lastGrant, k);
        end
      end
    end
  end

  // Register file. The host write has priority over the arbiter grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_hostWr) begin
      r_mem[xa_addr] <= xa_data_wr;
    end else if (w_grantVld) begin
      r_mem[r_bufAddr[w_grantIdx]] <= r_bufData[w_grantIdx];
    end
  end

  // Host read path. The read samples the array before this edge's write,
  // which gives read-before-write ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdData <= '0;
      r_rdVld  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rdVld <= w_hostRd;
      r_err   <= w_hostErr;
      if (w_hostRd) r_rdData <= r_mem[xa_addr];
    end
  end

  // Holding buffers. A buffer drained at this edge was still full when it
  // was sampled, so a strobe in the same cycle is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_ovf       <= '0;
      r_lastGrant <= LG_W'(NUM_WA - 1);
      for (int i = 0; i < NUM_WA; i++) begin
        r_bufAddr[i] <= '0;
        r_bufData[i] <= '0;
      end
    end else begin
      r_ovf <= wa_wr_s & r_valid;
      if (w_grantVld) r_lastGrant <= w_grantIdx;
      for (int i = 0; i < NUM_WA; i++) begin
        if (w_grantVld && (w_grantIdx == LG_W'(i))) begin
          r_valid[i] <= 1'b0;
        end else if (wa_wr_s[i] && !r_valid[i]) begin
          r_valid[i]   <= 1'b1;
          r_bufAddr[i] <= wa_addr[i*ADDR_W +: ADDR_W];
          r_bufData[i] <= wa_data_wr[i*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_sif_mc.sv
// -----------------------------------------------------------------------------
// tb_sif_mc
// Self-checking bench for sif_mc with the default parameters.
// A table of directed vectors runs first. A mid-operation reset sequence
// follows. The last phase applies random traffic and compares every cycle
// against a behavioural model.
// -----------------------------------------------------------------------------
module tb_sif_mc;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int NUM_WA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        xa_wr_s, xa_rd_s;
  logic [3:0]  xa_addr;
  logic [15:0] xa_data_wr, xa_data_rd;
  logic        xa_rd_vld, xa_err;
  logic [1:0]  wa_wr_s, wa_rdy, wa_ovf;
  logic [7:0]  wa_addr;
  logic [31:0] wa_data_wr;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  sif_mc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WA(NUM_WA)) dut (
    .clk(clk), .rst(rst),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr),
    .xa_data_wr(xa_data_wr), .xa_data_rd(xa_data_rd),
    .xa_rd_vld(xa_rd_vld), .xa_err(xa_err),
    .wa_wr_s(wa_wr_s), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
    .wa_rdy(wa_rdy), .wa_ovf(wa_ovf)
  );

  typedef struct {
    logic        wr, rd;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  waWr;
    logic [7:0]  waAddr;
    logic [31:0] waData;
    logic        expVld, expErr;
    logic [15:0] expData;
    logic [1:0]  expRdy, expOvf;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [15:0] mMem [16];
  logic [1:0]  mValid;
  logic [3:0]  mBufAddr [2];
  logic [15:0] mBufData [2];
  int          mLast;
  logic [15:0] mData;
  logic        mVld, mErr;
  logic [1:0]  mOvf;

  function automatic vec_t mkVec(logic wr, logic rd, logic [3:0] addr, logic [15:0] data,
                                 logic [1:0] waWr, logic [7:0] waAddr, logic [31:0] waData,
                                 logic expVld, logic expErr, logic [15:0] expData,
                                 logic [1:0] expRdy, logic [1:0] expOvf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.data = data;
    v.waWr = waWr; v.waAddr = waAddr; v.waData = waData;
    v.expVld = expVld; v.expErr = expErr; v.expData = expData;
    v.expRdy = expRdy; v.expOvf = expOvf;
    return v;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expVld, input logic expErr,
                             input logic [15:0] expData, input logic [1:0] expRdy,
                             input logic [1:0] expOvf);
    check1({tag, ".rd_vld"}, 32'(xa_rd_vld), 32'(expVld));
    check1({tag, ".err"},    32'(xa_err),    32'(expErr));
    check1({tag, ".data"},   32'(xa_data_rd), 32'(expData));
    check1({tag, ".rdy"},    32'(wa_rdy),    32'(expRdy));
    check1({tag, ".ovf"},    32'(wa_ovf),    32'(expOvf));
  endtask

  // Drive one cycle of inputs at the falling edge and return just after the
  // next rising edge so that the outputs can be sampled.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr,
                               input logic [15:0] data, input logic [1:0] waWr,
                               input logic [7:0] waAddr, input logic [31:0] waData);
    @(negedge clk);
    xa_wr_s = wr; xa_rd_s = rd; xa_addr = addr; xa_data_wr = data;
    wa_wr_s = waWr; wa_addr = waAddr; wa_data_wr = waData;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mMem[i] = '0;
    mValid = '0; mLast = NUM_WA - 1;
    mData = '0; mVld = 1'b0; mErr = 1'b0; mOvf = '0;
    for (int i = 0; i < NUM_WA; i++) begin mBufAddr[i] = '0; mBufData[i] = '0; end
  endtask

  // Advances the model by one clock edge, using the given inputs.
  task automatic modelStep(input logic wr, input logic rd, input logic [3:0] addr,
                           input logic [15:0] data, input logic [1:0] waWr,
                           input logic [7:0] waAddr, input logic [31:0] waData);
    logic       hostWr;
    logic [1:0] oldValid;
    int         g;
    hostWr   = wr && !rd;
    mVld     = rd && !wr;
    mErr     = wr && rd;
    if (mVld) mData = mMem[addr];
    oldValid = mValid;
    mOvf     = waWr & oldValid;
    g = -1;
    if (!hostWr) begin
      for (int k = 1; k <= NUM_WA; k++) begin
        int c;
        c = (mLast + k) % NUM_WA;
        if (g < 0 && oldValid[c]) g = c;
      end
    end
    if (hostWr) mMem[addr] = data;
    else if (g >= 0) begin
      mMem[mBufAddr[g]] = mBufData[g];
      mValid[g] = 1'b0;
      mLast = g;
    end
    for (int i = 0; i < NUM_WA; i++) begin
      if (waWr[i] && !oldValid[i]) begin
        mValid[i]   = 1'b1;
        mBufAddr[i] = waAddr[i*4 +: 4];
        mBufData[i] = waData[i*16 +: 16];
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    xa_wr_s = 0; xa_rd_s = 0; xa_addr = '0; xa_data_wr = '0;
    wa_wr_s = '0; wa_addr = '0; wa_data_wr = '0;

    // Directed vectors: wr rd addr data | waWr waAddr waData | vld err data rdy ovf
    vecs.push_back(mkVec(1,0,4'd3,16'h00A5, 2'b00,8'h00,32'h0,            0,0,16'h0000,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd3,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h00A5,2'b11,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b00,8'h00,32'h0,            0,0,16'h00A5,2'b11,2'b00));
    vecs.push_back(mkVec(1,1,4'd5,16'hFFFF, 2'b00,8'h00,32'h0,            0,1,16'h00A5,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd5,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h0000,2'b11,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b11,8'h21,32'h2222_1111,    0,0,16'h0000,2'b00,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b00,8'h00,32'h0,            0,0,16'h0000,2'b01,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b00,8'h00,32'h0,            0,0,16'h0000,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd1,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h1111,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd2,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h2222,2'b11,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b01,8'h06,32'h0000_0606,    0,0,16'h2222,2'b10,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b01,8'h06,32'h0000_0BAD,    0,0,16'h2222,2'b11,2'b01));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b00,8'h00,32'h0,            0,0,16'h2222,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd6,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h0606,2'b11,2'b00));
    vecs.push_back(mkVec(0,0,4'd0,16'h0000, 2'b10,8'h40,32'h1234_0000,    0,0,16'h0606,2'b01,2'b00));
    vecs.push_back(mkVec(1,0,4'd4,16'hBEEF, 2'b00,8'h00,32'h0,            0,0,16'h0606,2'b01,2'b00));
    vecs.push_back(mkVec(0,1,4'd4,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'hBEEF,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd4,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h1234,2'b11,2'b00));
    vecs.push_back(mkVec(0,1,4'd0,16'h0000, 2'b00,8'h00,32'h0,            1,0,16'h0000,2'b11,2'b00));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 16'h0000, 2'b11, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
                    vecs[i].waWr, vecs[i].waAddr, vecs[i].waData);
      checkOutput($sformatf("vec%0d", i), vecs[i].expVld, vecs[i].expErr,
                  vecs[i].expData, vecs[i].expRdy, vecs[i].expOvf);
    end

    // Reset during operation, with both buffers full and read data non-zero
    applyStimulus(0, 1, 4'd4, 16'h0, 2'b00, 8'h00, 32'h0);
    checkOutput("preRstRd", 1, 0, 16'h1234, 2'b11, 2'b00);
    applyStimulus(0, 0, 4'd0, 16'h0, 2'b11, 8'h53, 32'hDEAD_BEEF);
    checkOutput("preRstWa", 0, 0, 16'h1234, 2'b00, 2'b00);
    xa_wr_s = 0; xa_rd_s = 0; wa_wr_s = '0;
    #2 rst = 1'b1;
    #1 checkOutput("rstAsync", 0, 0, 16'h0000, 2'b11, 2'b00);
    @(posedge clk);
    #1 checkOutput("rstHeld", 0, 0, 16'h0000, 2'b11, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1, 4'd3, 16'h0, 2'b00, 8'h00, 32'h0);
    checkOutput("postRst3", 1, 0, 16'h0000, 2'b11, 2'b00);
    applyStimulus(0, 1, 4'd4, 16'h0, 2'b00, 8'h00, 32'h0);
    checkOutput("postRst4", 1, 0, 16'h0000, 2'b11, 2'b00);
    applyStimulus(0, 1, 4'd5, 16'h0, 2'b00, 8'h00, 32'h0);
    checkOutput("postRst5", 1, 0, 16'h0000, 2'b11, 2'b00);

    // Random traffic against the model. The DUT only saw reads since reset.
    modelReset();
    for (int c = 0; c < 600; c++) begin
      logic        wr, rd;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [1:0]  waWr;
      logic [7:0]  waAddr;
      logic [31:0] waData;
      wr     = ($urandom_range(0, 9) < 3);
      rd     = ($urandom_range(0, 9) < 3);
      addr   = 4'($urandom_range(0, 7));
      data   = 16'($urandom);
      waWr   = 2'($urandom_range(0, 3));
      waAddr = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      waData = $urandom;
      applyStimulus(wr, rd, addr, data, waWr, waAddr, waData);
      modelStep(wr, rd, addr, data, waWr, waAddr, waData);
      checkOutput($sformatf("rand%0d", c), mVld, mErr, mData, ~mValid, mOvf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
